// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch (IF) and data (DM) requesters; DM has priority, bounded IF starvation.
// Grant one cycle after the request, requester ack one cycle after mem_ack_i (or watchdog expiry); stall_o is combinational.
module mem_port_arbiter #(
  parameter int IF_STARVE_MAX = 4,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic        err_o
);

  localparam int SW = $clog2(IF_STARVE_MAX + 1);
  localparam int WW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t        state;
  logic          own_dm;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wd_cnt;
  logic          grant_if;
  logic          grant_dm;

  // IF wins only when DM is absent or IF has been passed over IF_STARVE_MAX times
  assign grant_if = if_req_i && (!dm_req_i || (starve_cnt == SW'(IF_STARVE_MAX)));
  assign grant_dm = dm_req_i && !grant_if;
  assign stall_o  = (if_req_i && !if_ack_o) || (dm_req_i && !dm_ack_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      own_dm      <= 1'b0;
      starve_cnt  <= '0;
      wd_cnt      <= '0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_data_o   <= '0;
      if_ack_o    <= 1'b0;
      dm_rdata_o  <= '0;
      dm_ack_o    <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_if) begin
            state       <= MEM;
            own_dm      <= 1'b0;
            mem_en_o    <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            starve_cnt  <= '0;
          end else if (grant_dm) begin
            state       <= MEM;
            own_dm      <= 1'b1;
            mem_en_o    <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            if (!if_req_i) begin
              starve_cnt <= '0;
            end else if (starve_cnt != SW'(IF_STARVE_MAX)) begin
              starve_cnt <= starve_cnt + SW'(1);
            end
          end else if (!if_req_i) begin
            starve_cnt <= '0;
          end
        end
        MEM: begin
          if (mem_ack_i) begin
            state    <= RESP;
            mem_en_o <= 1'b0;
            wd_cnt   <= '0;
            if (own_dm) begin
              dm_ack_o <= 1'b1;
              if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
            end else begin
              if_ack_o  <= 1'b1;
              if_data_o <= mem_rdata_i;
            end
          end else if (wd_cnt == WW'(TIMEOUT_CYC - 1)) begin
            // Abort with a zero response so the pipeline never deadlocks
            state    <= RESP;
            mem_en_o <= 1'b0;
            wd_cnt   <= '0;
            err_o    <= 1'b1;
            if (own_dm) begin
              dm_ack_o <= 1'b1;
              if (!mem_we_o) dm_rdata_o <= '0;
            end else begin
              if_ack_o  <= 1'b1;
              if_data_o <= '0;
            end
          end else begin
            wd_cnt <= wd_cnt + WW'(1);
          end
        end
        RESP: begin
          state    <= IDLE;
          if_ack_o <= 1'b0;
          dm_ack_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scripted requesters, a latency-programmable memory responder,
// and a per-cycle transaction-level reference for acks, data, memory fields, stall and error.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_ack;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        stall;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.IF_STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ack_o(if_ack),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata), .dm_ack_o(dm_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
    .stall_o(stall), .err_o(err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until either ack is seen; reports which one.
  task automatic wait_any(input int budget, output bit got, output bit is_dm);
    got   = 1'b0;
    is_dm = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (if_ack || dm_ack) begin
        got   = 1'b1;
        is_dm = dm_ack;
        break;
      end
    end
  endtask

  // Memory responder: acks mem_lat cycles after mem_en rises; reads return stored data or an address pattern.
  int          mem_lat = 1;
  int          en_cycles = 0;
  bit          force_ack = 1'b0;
  logic [31:0] store [logic [31:0]];

  always begin
    @(posedge clk);
    #2;
    mem_ack   = force_ack;
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_en) begin
      if (en_cycles == mem_lat) mem_ack = 1'b1;
      en_cycles++;
    end else begin
      en_cycles = 0;
    end
    if (mem_ack) begin
      if (mem_en && mem_we) store[mem_addr] = mem_wdata;
      mem_rdata = store.exists(mem_addr) ? store[mem_addr] : (mem_addr ^ 32'h8C22_0014);
    end
  end

  // Reference: at most one access open; it starts the cycle after it is chosen, ends on memory ack
  // or after TIMEOUT open cycles, and its owner sees exactly one completion cycle afterwards.
  bit          seen_rst = 1'b0;
  bit          open_acc = 1'b0;
  bit          done_acc = 1'b0;
  bit          g_dm = 1'b0;
  bit          g_we = 1'b0;
  logic [31:0] g_addr = '0;
  logic [31:0] g_wdata = '0;
  int          open_cycles = 0;
  int          dm_wins_over_if = 0;
  logic [31:0] r_if_data = '0;
  logic [31:0] r_dm_rdata = '0;
  bit          r_err = 1'b0;

  always @(negedge clk) begin
    if (seen_rst) begin
      check1("cmp_mem_en", mem_en, open_acc);
      check1("cmp_if_ack", if_ack, done_acc && !g_dm);
      check1("cmp_dm_ack", dm_ack, done_acc && g_dm);
      check1("cmp_ack_excl", if_ack && dm_ack, 1'b0);
      check32("cmp_if_data", if_data, r_if_data);
      check32("cmp_dm_rdata", dm_rdata, r_dm_rdata);
      check1("cmp_err", err, r_err);
      check1("cmp_stall", stall, (if_req && !(done_acc && !g_dm)) || (dm_req && !(done_acc && g_dm)));
      if (open_acc) begin
        check32("cmp_mem_addr", mem_addr, g_addr);
        check1("cmp_mem_we", mem_we, g_we);
        if (g_we) check32("cmp_mem_wdata", mem_wdata, g_wdata);
      end
    end
    if (rst) begin
      seen_rst = 1'b1;
      open_acc = 1'b0; done_acc = 1'b0; g_dm = 1'b0; g_we = 1'b0;
      g_addr = '0; g_wdata = '0; open_cycles = 0; dm_wins_over_if = 0;
      r_if_data = '0; r_dm_rdata = '0; r_err = 1'b0;
    end else if (done_acc) begin
      done_acc = 1'b0;
    end else if (open_acc) begin
      open_cycles++;
      if (mem_ack || open_cycles == TIMEOUT) begin
        open_acc = 1'b0;
        done_acc = 1'b1;
        if (!mem_ack) r_err = 1'b1;
        if (!g_dm) r_if_data = mem_ack ? mem_rdata : 32'h0;
        else if (!g_we) r_dm_rdata = mem_ack ? mem_rdata : 32'h0;
      end
    end else if (if_req && (!dm_req || dm_wins_over_if == STARVE_MAX)) begin
      open_acc = 1'b1; open_cycles = 0; dm_wins_over_if = 0;
      g_dm = 1'b0; g_we = 1'b0; g_addr = if_addr;
    end else if (dm_req) begin
      open_acc = 1'b1; open_cycles = 0;
      g_dm = 1'b1; g_we = dm_we; g_addr = dm_addr; g_wdata = dm_wdata;
      dm_wins_over_if = if_req ? dm_wins_over_if + 1 : 0;
    end else begin
      dm_wins_over_if = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    bit got, is_dm;
    int cnt;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    check1("rst_mem_en", mem_en, 1'b0);
    check1("rst_err", err, 1'b0);
    check32("rst_mem_addr", mem_addr, 32'h0);
    check32("rst_if_data", if_data, 32'h0);
    check1("rst_stall", stall, 1'b0);
    tick();

    // Single fetch, memory answers one cycle after mem_en
    if_req = 1'b1; if_addr = 32'h0000_0010;
    tick();
    check1("fetch_mem_en_c1", mem_en, 1'b1);
    check32("fetch_mem_addr", mem_addr, 32'h10);
    check1("fetch_mem_we", mem_we, 1'b0);
    tick();
    check1("fetch_no_ack_c2", if_ack, 1'b0);
    check1("fetch_stall_c2", stall, 1'b1);
    tick();
    check1("fetch_ack_c3", if_ack, 1'b1);
    check32("fetch_data_c3", if_data, 32'h8C22_0004);
    check1("fetch_stall_c3", stall, 1'b0);
    if_req = 1'b0;
    tick();
    check1("fetch_ack_pulse", if_ack, 1'b0);
    check32("fetch_data_held", if_data, 32'h8C22_0004);

    // Simultaneous IF + DM write: DM first
    if_req = 1'b1; if_addr = 32'h20;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hCAFE_F00D;
    tick();
    check1("simul_mem_we", mem_we, 1'b1);
    check32("simul_mem_wdata", mem_wdata, 32'hCAFE_F00D);
    check32("simul_mem_addr", mem_addr, 32'h40);
    wait_any(20, got, is_dm);
    check1("simul_first_seen", got, 1'b1);
    check1("simul_first_is_dm", is_dm, 1'b1);
    check32("simul_dm_rdata_kept", dm_rdata, 32'h0);
    dm_req = 1'b0; dm_we = 1'b0;
    wait_any(20, got, is_dm);
    check1("simul_second_seen", got, 1'b1);
    check1("simul_second_is_if", is_dm, 1'b0);
    check32("simul_if_data", if_data, 32'h8C22_0034);
    if_req = 1'b0;
    tick();

    // Starvation: DM re-requests after every ack while IF waits
    if_req = 1'b1; if_addr = 32'h30;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int k = 0; k < 5; k++) begin
      wait_any(20, got, is_dm);
      check1("starve_seen", got, 1'b1);
      check1("starve_order_dm", is_dm, k < 4);
      if (is_dm) begin
        dm_req = 1'b0;
        tick();
        dm_req = 1'b1;
      end else begin
        if_req = 1'b0;
      end
    end
    wait_any(20, got, is_dm);
    check1("starve_after_if_dm", is_dm, 1'b1);
    check32("starve_dm_rdata", dm_rdata, 32'h8C22_0114);
    dm_req = 1'b0;
    tick();
    // Counter cleared: with both asking again, DM wins
    if_req = 1'b1; dm_req = 1'b1;
    wait_any(20, got, is_dm);
    check1("starve_cleared_dm_first", is_dm, 1'b1);
    dm_req = 1'b0;
    wait_any(20, got, is_dm);
    check1("starve_cleared_if_next", is_dm, 1'b0);
    if_req = 1'b0;
    tick();

    // Watchdog: memory never answers a DM read
    mem_lat = 100000;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h200;
    tick();
    cnt = 0;
    while (mem_en && cnt < 100) begin
      cnt++;
      tick();
    end
    check32("to_en_cycles", cnt, 32'd64);
    check1("to_dm_ack", dm_ack, 1'b1);
    check32("to_dm_rdata_zero", dm_rdata, 32'h0);
    check1("to_err_set", err, 1'b1);
    dm_req = 1'b0;
    tick();
    check1("to_err_sticky", err, 1'b1);
    check1("to_ack_pulse", dm_ack, 1'b0);
    mem_lat = 1;
    if_req = 1'b1; if_addr = 32'h44;
    wait_any(20, got, is_dm);
    check1("to_next_is_if", got && !is_dm, 1'b1);
    check32("to_next_data", if_data, 32'h8C22_0050);
    check1("to_err_still", err, 1'b1);
    if_req = 1'b0;
    tick();

    // Reset during an open write, then a stray memory ack
    mem_lat = 100000;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h1234_5678;
    tick(); tick();
    check1("rstmid_in_mem", mem_en, 1'b1);
    rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
    tick();
    rst = 1'b0; force_ack = 1'b1;
    check1("rstmid_mem_en", mem_en, 1'b0);
    check1("rstmid_mem_we", mem_we, 1'b0);
    check32("rstmid_mem_addr", mem_addr, 32'h0);
    check32("rstmid_mem_wdata", mem_wdata, 32'h0);
    check32("rstmid_if_data", if_data, 32'h0);
    check32("rstmid_dm_rdata", dm_rdata, 32'h0);
    check1("rstmid_err", err, 1'b0);
    tick();
    force_ack = 1'b0;
    check1("rstmid_late_if_ack", if_ack, 1'b0);
    check1("rstmid_late_dm_ack", dm_ack, 1'b0);
    tick();
    check1("rstmid_idle_if_ack", if_ack, 1'b0);
    check1("rstmid_idle_dm_ack", dm_ack, 1'b0);
    check1("rstmid_idle_mem_en", mem_en, 1'b0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
